// File: rtl/bpred_port_arbiter_if.sv
// Bundle between the branch predictor port arbiter and its neighbours: the
// MEM-stage update producer, the fetch-stage lookup requester and the
// single-ported predictor table SRAM.
//   slave  : arbiter side (consumes updates/lookups, drives the table port)
//   master : environment side (MEM stage, fetch stage, table observer)
// Signals:
//   upd_valid/upd_pc/upd_taken/upd_target  resolved branch from MEM
//   upd_ready                               FIFO has room (registered occupancy)
//   fetch_req/fetch_pc                      lookup request from fetch
//   fetch_grant/fetch_stall                 lookup granted / denied (hold PC)
//   tbl_en/tbl_we/tbl_idx                   table port control
//   tbl_wtag/tbl_wtaken/tbl_wtarget         table write data
//   q_count                                 update FIFO occupancy
interface bpred_port_arbiter_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 6
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              upd_ready;
  logic              fetch_req;
  logic [31:0]       fetch_pc;
  logic              fetch_grant;
  logic              fetch_stall;
  logic              tbl_en;
  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_idx;
  logic [29-IDX_W:0] tbl_wtag;
  logic              tbl_wtaken;
  logic [31:0]       tbl_wtarget;
  logic [CNT_W-1:0]  q_count;

  modport slave (
    input  upd_valid, upd_pc, upd_taken, upd_target, fetch_req, fetch_pc,
    output upd_ready, fetch_grant, fetch_stall, tbl_en, tbl_we, tbl_idx,
           tbl_wtag, tbl_wtaken, tbl_wtarget, q_count
  );

  modport master (
    output upd_valid, upd_pc, upd_taken, upd_target, fetch_req, fetch_pc,
    input  upd_ready, fetch_grant, fetch_stall, tbl_en, tbl_we, tbl_idx,
           tbl_wtag, tbl_wtaken, tbl_wtarget, q_count
  );
endinterface

// File: rtl/bpred_port_arbiter.sv
// Arbitrates the single-ported BTB/BHT table between fetch lookups and
// MEM-stage branch-resolution updates. Updates are buffered in a small FIFO
// and written whenever fetch leaves the port idle. When the FIFO fills, or an
// update has waited STARVE_MAX cycles without any table write, the arbiter
// enters a forced-drain state that stalls fetch until the FIFO is empty.
// Ports:
//   clk  clock, all state on rising edge
//   rst  asynchronous reset, active high
//   bus  bpred_port_arbiter_if.slave (update, fetch and table signals)
module bpred_port_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic                 clk,
  input logic                 rst,
  bpred_port_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] StvMax  = STV_W'(STARVE_MAX);

  typedef enum logic [0:0] {StNormal, StForce} state_e;

  // FIFO storage; pc keeps only bits [31:2] since the low two are always zero
  logic [29:0] pc_mem     [DEPTH];
  logic        taken_mem  [DEPTH];
  logic [31:0] target_mem [DEPTH];

  state_e           state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STV_W-1:0] starve_q, starve_d;

  logic        push;
  logic        deq;
  logic        nonempty;
  logic        fetch_grant;
  logic        fetch_stall;
  logic [29:0] head_pc;

  assign nonempty      = (count_q != '0);
  // Ready follows registered occupancy only: a full FIFO stays not-ready
  // even in a cycle where it is popping.
  assign bus.upd_ready = (count_q != CntFull);
  assign push          = bus.upd_valid & bus.upd_ready;

  always_comb begin
    fetch_grant = 1'b0;
    fetch_stall = 1'b0;
    deq         = 1'b0;
    state_d     = state_q;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    starve_d    = starve_q;

    unique case (state_q)
      StNormal: begin
        fetch_grant = bus.fetch_req;
        deq         = ~bus.fetch_req & nonempty;
      end
      StForce: begin
        fetch_stall = bus.fetch_req;
        deq         = nonempty;
      end
    endcase

    if (push && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && deq) begin
      count_d = count_q - CNT_W'(1);
    end
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (deq) begin
      head_d = head_q + PTR_W'(1);
    end

    // Measures how long the head has waited with no table write at all
    if (!nonempty || deq) begin
      starve_d = '0;
    end else if (starve_q != StvMax) begin
      starve_d = starve_q + STV_W'(1);
    end

    unique case (state_q)
      StNormal: begin
        if (count_d == CntFull || starve_q == StvMax) begin
          state_d = StForce;
        end
      end
      StForce: begin
        if (count_d == '0) begin
          state_d = StNormal;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StNormal;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Payload storage needs no reset: validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]     <= bus.upd_pc[31:2];
      taken_mem[tail_q]  <= bus.upd_taken;
      target_mem[tail_q] <= bus.upd_target;
    end
  end

  assign head_pc = pc_mem[head_q];

  assign bus.fetch_grant = fetch_grant;
  assign bus.fetch_stall = fetch_stall;
  assign bus.tbl_en      = fetch_grant | deq;
  assign bus.tbl_we      = deq;
  assign bus.tbl_idx     = deq ? head_pc[IDX_W-1:0] : bus.fetch_pc[IDX_W+1:2];
  // Write data always reflects the head so it is stable while no write issues
  assign bus.tbl_wtag    = head_pc[29:IDX_W];
  assign bus.tbl_wtaken  = taken_mem[head_q];
  assign bus.tbl_wtarget = target_mem[head_q];
  assign bus.q_count     = count_q;

endmodule
